// File: rtl/mcsr_file.sv
// Machine-mode CSR file: trap/interrupt state, local interrupt lines, selectable mtvec mode.
// Define MCSR_COUNTERS_EN to implement mcycle/minstret/mcountinhibit; otherwise those indices read 0.
module mcsr_file #(
    parameter int NLINT = 4,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             cpurst,
    input  logic             csr_wr_en,
    input  logic [11:0]      csr_wr_idx,
    input  logic [31:0]      csr_wr_data,
    input  logic [11:0]      csr_rd_idx,
    output logic [31:0]      csr_rd_data,
    output logic             csr_rd_ill,
    input  logic             exp_valid,
    input  logic [4:0]       exp_cause,
    input  logic [31:0]      exp_pc,
    input  logic [31:0]      exp_tval,
    input  logic             mret,
    input  logic             instr_ret,
    input  logic             irq_ms,
    input  logic             irq_mt,
    input  logic             irq_me,
    input  logic [NLINT-1:0] irq_local,
    output logic             int_req,
    input  logic             int_ack,
    input  logic [31:0]      int_pc,
    output logic [31:0]      trap_vec,
    output logic [31:0]      mepc_o,
    output logic             mstatus_mie
);

    localparam logic [31:0] LOCAL_MASK = ((32'h1 << NLINT) - 32'h1) << 16;
    localparam logic [31:0] MIE_MASK   = 32'h0000_0888 | LOCAL_MASK;

    logic        mie_bit;
    logic        mpie_bit;
    logic [31:0] mie_q;
    logic [29:0] mtvec_base;
    logic        mtvec_mode;
    logic [31:0] mscratch_q;
    logic [30:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;

    logic [31:0] mip_val;
    logic [31:0] pending;
    logic [4:0]  int_cause;
    logic        take_int;
    logic        wr_ok;

    always_comb begin
        mip_val = '0;
        mip_val[3]  = irq_ms;
        mip_val[7]  = irq_mt;
        mip_val[11] = irq_me;
        mip_val[16 +: NLINT] = irq_local;
    end

    assign pending = mip_val & mie_q;
    assign int_req = (pending != 32'h0) && mie_bit;

    // Lowest priority assigned first so higher-priority sources override it.
    always_comb begin
        int_cause = 5'd0;
        for (int i = 0; i < NLINT; i++) begin
            if (pending[16 + i]) int_cause = 5'(16 + i);
        end
        if (pending[7])  int_cause = 5'd7;
        if (pending[3])  int_cause = 5'd3;
        if (pending[11]) int_cause = 5'd11;
    end

    assign take_int = int_ack && int_req;
    assign wr_ok    = csr_wr_en && !take_int && !exp_valid && !mret;

    // Vectored offset applies only when an interrupt, not an exception, is the trap being taken.
    always_comb begin
        trap_vec = {mtvec_base, 2'b00};
        if (mtvec_mode && int_req && (int_ack || !exp_valid))
            trap_vec = {mtvec_base, 2'b00} + {25'b0, int_cause, 2'b00};
    end

    assign mepc_o      = {mepc_q, 1'b0};
    assign mstatus_mie = mie_bit;

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            mie_bit    <= 1'b0;
            mpie_bit   <= 1'b0;
            mie_q      <= '0;
            mtvec_base <= '0;
            mtvec_mode <= 1'b0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (take_int) begin
            mpie_bit <= mie_bit;
            mie_bit  <= 1'b0;
            mepc_q   <= int_pc[31:1];
            mcause_q <= {1'b1, 26'b0, int_cause};
            mtval_q  <= '0;
        end else if (exp_valid) begin
            mpie_bit <= mie_bit;
            mie_bit  <= 1'b0;
            mepc_q   <= exp_pc[31:1];
            mcause_q <= {27'b0, exp_cause};
            mtval_q  <= exp_tval;
        end else if (mret) begin
            mie_bit  <= mpie_bit;
            mpie_bit <= 1'b1;
        end else if (wr_ok) begin
            case (csr_wr_idx)
                12'h300: begin
                    mie_bit  <= csr_wr_data[3];
                    mpie_bit <= csr_wr_data[7];
                end
                12'h304: mie_q <= csr_wr_data & MIE_MASK;
                12'h305: begin
                    mtvec_base <= csr_wr_data[31:2];
                    mtvec_mode <= csr_wr_data[0];
                end
                12'h340: mscratch_q <= csr_wr_data;
                12'h341: mepc_q     <= csr_wr_data[31:1];
                12'h342: mcause_q   <= csr_wr_data;
                12'h343: mtval_q    <= csr_wr_data;
                default: ;
            endcase
        end
    end

`ifdef MCSR_COUNTERS_EN
    logic [CNT_W-1:0] mcycle_q;
    logic [CNT_W-1:0] minstret_q;
    logic             inh_cy;
    logic             inh_ir;
    logic [63:0]      mcycle_ext;
    logic [63:0]      minstret_ext;

    assign mcycle_ext   = 64'(mcycle_q);
    assign minstret_ext = 64'(minstret_q);

    // A write to either half owns the counter for that cycle, so no increment.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
            inh_cy     <= 1'b0;
            inh_ir     <= 1'b0;
        end else begin
            if (wr_ok && csr_wr_idx == 12'h320) begin
                inh_cy <= csr_wr_data[0];
                inh_ir <= csr_wr_data[2];
            end
            if (wr_ok && csr_wr_idx == 12'hB00)
                mcycle_q <= {mcycle_q[CNT_W-1:32], csr_wr_data};
            else if (wr_ok && csr_wr_idx == 12'hB80)
                mcycle_q <= CNT_W'({csr_wr_data, mcycle_q[31:0]});
            else if (!inh_cy)
                mcycle_q <= mcycle_q + CNT_W'(1);
            if (wr_ok && csr_wr_idx == 12'hB02)
                minstret_q <= {minstret_q[CNT_W-1:32], csr_wr_data};
            else if (wr_ok && csr_wr_idx == 12'hB82)
                minstret_q <= CNT_W'({csr_wr_data, minstret_q[31:0]});
            else if (instr_ret && !inh_ir)
                minstret_q <= minstret_q + CNT_W'(1);
        end
    end
`else
    logic unused_counter_inputs;
    assign unused_counter_inputs = instr_ret;
`endif

    always_comb begin
        csr_rd_data = '0;
        csr_rd_ill  = 1'b0;
        case (csr_rd_idx)
            12'h300: csr_rd_data = {19'b0, 2'b11, 3'b0, mpie_bit, 3'b0, mie_bit, 3'b0};
            12'h301: csr_rd_data = '0;
            12'h304: csr_rd_data = mie_q;
            12'h305: csr_rd_data = {mtvec_base, 1'b0, mtvec_mode};
            12'h340: csr_rd_data = mscratch_q;
            12'h341: csr_rd_data = {mepc_q, 1'b0};
            12'h342: csr_rd_data = mcause_q;
            12'h343: csr_rd_data = mtval_q;
            12'h344: csr_rd_data = mip_val;
            12'hF11, 12'hF12, 12'hF13, 12'hF14: csr_rd_data = '0;
`ifdef MCSR_COUNTERS_EN
            12'h320: csr_rd_data = {29'b0, inh_ir, 1'b0, inh_cy};
            12'hB00: csr_rd_data = mcycle_ext[31:0];
            12'hB80: csr_rd_data = mcycle_ext[63:32];
            12'hB02: csr_rd_data = minstret_ext[31:0];
            12'hB82: csr_rd_data = minstret_ext[63:32];
`else
            12'h320, 12'hB00, 12'hB80, 12'hB02, 12'hB82: csr_rd_data = '0;
`endif
            default: csr_rd_ill = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mcsr_file.sv
// Directed self-checking bench for mcsr_file (NLINT=4, CNT_W=64).
// Counter checks are compiled in only when MCSR_COUNTERS_EN is defined.
module tb_mcsr_file;

    logic        clk;
    logic        cpurst;
    logic        csr_wr_en;
    logic [11:0] csr_wr_idx;
    logic [31:0] csr_wr_data;
    logic [11:0] csr_rd_idx;
    logic [31:0] csr_rd_data;
    logic        csr_rd_ill;
    logic        exp_valid;
    logic [4:0]  exp_cause;
    logic [31:0] exp_pc;
    logic [31:0] exp_tval;
    logic        mret;
    logic        instr_ret;
    logic        irq_ms;
    logic        irq_mt;
    logic        irq_me;
    logic [3:0]  irq_local;
    logic        int_req;
    logic        int_ack;
    logic [31:0] int_pc;
    logic [31:0] trap_vec;
    logic [31:0] mepc_o;
    logic        mstatus_mie;

    int total = 0;
    int bad   = 0;

    mcsr_file #(.NLINT(4), .CNT_W(64)) dut (
        .clk(clk), .cpurst(cpurst),
        .csr_wr_en(csr_wr_en), .csr_wr_idx(csr_wr_idx), .csr_wr_data(csr_wr_data),
        .csr_rd_idx(csr_rd_idx), .csr_rd_data(csr_rd_data), .csr_rd_ill(csr_rd_ill),
        .exp_valid(exp_valid), .exp_cause(exp_cause), .exp_pc(exp_pc), .exp_tval(exp_tval),
        .mret(mret), .instr_ret(instr_ret),
        .irq_ms(irq_ms), .irq_mt(irq_mt), .irq_me(irq_me), .irq_local(irq_local),
        .int_req(int_req), .int_ack(int_ack), .int_pc(int_pc),
        .trap_vec(trap_vec), .mepc_o(mepc_o), .mstatus_mie(mstatus_mie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // One writeback cycle carrying a CSR write.
    task automatic applyStimulus(input logic [11:0] idx, input logic [31:0] data);
        csr_wr_en   = 1'b1;
        csr_wr_idx  = idx;
        csr_wr_data = data;
        stepClock();
        csr_wr_en   = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [11:0] idx, input logic [31:0] exp);
        csr_rd_idx = idx;
        #1;
        checkOutput(tag, csr_rd_data, exp);
    endtask

    initial begin
        cpurst = 1'b0; csr_wr_en = 1'b0; csr_wr_idx = '0; csr_wr_data = '0;
        csr_rd_idx = 12'h300; exp_valid = 1'b0; exp_cause = '0; exp_pc = '0;
        exp_tval = '0; mret = 1'b0; instr_ret = 1'b0; irq_ms = 1'b0; irq_mt = 1'b0;
        irq_me = 1'b0; irq_local = '0; int_ack = 1'b0; int_pc = '0;

        // Reset asserted between clock edges must act immediately.
        #3 cpurst = 1'b1;
        #1;
        checkOutput("rst_int_req", {31'b0, int_req}, 32'h0);
        checkOutput("rst_trap_vec", trap_vec, 32'h0);
        checkOutput("rst_mepc", mepc_o, 32'h0);
        checkOutput("rst_mie", {31'b0, mstatus_mie}, 32'h0);
        readCheck("rst_mstatus", 12'h300, 32'h0000_1800);
        stepClock();
        cpurst = 1'b0;
        stepClock();

        // Vectored mtvec, machine external + timer pending.
        applyStimulus(12'h305, 32'h0000_1003);
        readCheck("mtvec_rb", 12'h305, 32'h0000_1001);
        applyStimulus(12'h304, 32'h0000_0880);
        readCheck("mie_rb", 12'h304, 32'h0000_0880);
        applyStimulus(12'h300, 32'h0000_0008);
        checkOutput("mie_set", {31'b0, mstatus_mie}, 32'h1);
        irq_me = 1'b1; irq_mt = 1'b1;
        #1;
        checkOutput("irq_req", {31'b0, int_req}, 32'h1);
        checkOutput("irq_vec", trap_vec, 32'h0000_102C);
        readCheck("mip_rb", 12'h344, 32'h0000_0880);
        int_ack = 1'b1; int_pc = 32'h0000_0200;
        stepClock();
        int_ack = 1'b0;
        checkOutput("ack_mepc", mepc_o, 32'h0000_0200);
        checkOutput("ack_req_drop", {31'b0, int_req}, 32'h0);
        readCheck("ack_mcause", 12'h342, 32'h8000_000B);
        readCheck("ack_mstatus", 12'h300, 32'h0000_1880);
        readCheck("ack_mtval", 12'h343, 32'h0);
        irq_me = 1'b0; irq_mt = 1'b0;

        // Exception with a colliding CSR write, then mret.
        applyStimulus(12'h300, 32'h0000_0008);
        applyStimulus(12'h340, 32'h0000_0055);
        exp_valid = 1'b1; exp_cause = 5'd2; exp_pc = 32'h40; exp_tval = 32'hDEAD;
        csr_wr_en = 1'b1; csr_wr_idx = 12'h340; csr_wr_data = 32'h1234;
        #1;
        checkOutput("exp_vec_base", trap_vec, 32'h0000_1000);
        stepClock();
        exp_valid = 1'b0; csr_wr_en = 1'b0;
        readCheck("exp_mcause", 12'h342, 32'h2);
        readCheck("exp_mtval", 12'h343, 32'h0000_DEAD);
        readCheck("exp_mscratch", 12'h340, 32'h55);
        readCheck("exp_mstatus", 12'h300, 32'h0000_1880);
        checkOutput("exp_mepc", mepc_o, 32'h40);
        mret = 1'b1;
        csr_wr_en = 1'b1; csr_wr_idx = 12'h340; csr_wr_data = 32'h99;
        stepClock();
        mret = 1'b0; csr_wr_en = 1'b0;
        checkOutput("mret_mie", {31'b0, mstatus_mie}, 32'h1);
        readCheck("mret_mstatus", 12'h300, 32'h0000_1888);
        readCheck("mret_wr_drop", 12'h340, 32'h55);

        // Local interrupt selection and priority against MSI.
        applyStimulus(12'h304, 32'h0008_0000);
        irq_local = 4'b1001;
        #1;
        checkOutput("lcl_req", {31'b0, int_req}, 32'h1);
        checkOutput("lcl_vec", trap_vec, 32'h0000_104C);
        applyStimulus(12'h304, 32'h0008_0008);
        irq_ms = 1'b1;
        #1;
        checkOutput("msi_prio_vec", trap_vec, 32'h0000_100C);
        irq_ms = 1'b0; irq_local = 4'b0000;
        #1;
        checkOutput("withdraw_req", {31'b0, int_req}, 32'h0);
        checkOutput("withdraw_vec", trap_vec, 32'h0000_1000);
        int_ack = 1'b1; int_pc = 32'h300;
        stepClock();
        int_ack = 1'b0;
        checkOutput("stray_ack_mepc", mepc_o, 32'h40);
        checkOutput("stray_ack_mie", {31'b0, mstatus_mie}, 32'h1);
        applyStimulus(12'h305, 32'h0000_2000);
        irq_ms = 1'b1;
        #1;
        checkOutput("direct_vec", trap_vec, 32'h0000_2000);
        irq_ms = 1'b0;
        applyStimulus(12'h341, 32'h0000_0101);
        readCheck("mepc_bit0", 12'h341, 32'h0000_0100);

`ifdef MCSR_COUNTERS_EN
        applyStimulus(12'hB00, 32'hFFFF_FFFF);
        applyStimulus(12'hB80, 32'hFFFF_FFFF);
        readCheck("cyc_lo_max", 12'hB00, 32'hFFFF_FFFF);
        stepClock();
        readCheck("cyc_lo_wrap", 12'hB00, 32'h0);
        readCheck("cyc_hi_wrap", 12'hB80, 32'h0);
        applyStimulus(12'h320, 32'h1);
        stepClock();
        stepClock();
        readCheck("cyc_frozen", 12'hB00, 32'h1);
        for (int i = 0; i < 3; i++) begin
            instr_ret = 1'b1;
            stepClock();
            instr_ret = 1'b0;
            stepClock();
        end
        readCheck("instret_3", 12'hB02, 32'h3);
        applyStimulus(12'h320, 32'h5);
        readCheck("inhibit_rb", 12'h320, 32'h5);
        instr_ret = 1'b1;
        stepClock();
        instr_ret = 1'b0;
        readCheck("instret_inh", 12'hB02, 32'h3);
`else
        applyStimulus(12'hB00, 32'h1234_5678);
        readCheck("nocnt_b00", 12'hB00, 32'h0);
        checkOutput("nocnt_ill", {31'b0, csr_rd_ill}, 32'h0);
`endif

        readCheck("ill_data", 12'h7C0, 32'h0);
        checkOutput("ill_flag", {31'b0, csr_rd_ill}, 32'h1);
        readCheck("f11_data", 12'hF11, 32'h0);
        checkOutput("f11_ill", {31'b0, csr_rd_ill}, 32'h0);
        applyStimulus(12'h301, 32'hFFFF_FFFF);
        readCheck("misa_ro", 12'h301, 32'h0);

        // Mid-cycle reset during operation clears state at once.
        stepClock();
        #3 cpurst = 1'b1;
        #1;
        checkOutput("rst2_mepc", mepc_o, 32'h0);
        checkOutput("rst2_mie", {31'b0, mstatus_mie}, 32'h0);
        readCheck("rst2_mie_reg", 12'h304, 32'h0);
        stepClock();
        cpurst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mcsr_file.md
# mcsr_file

Machine-mode CSR file for the writeback stage, generalising the current fixed three-source design. Adds parametrised local interrupt lines, selectable direct/vectored `mtvec`, an interrupt request/acknowledge handshake with the fetch unit, and optional 64-bit `mcycle`/`minstret` counters gated by `mcountinhibit`. Reads are combinational for decode. All state changes are committed from writeback.

## Interface
Parameters:
- `NLINT`, default 4: local interrupt lines, range 1..16. They map to `mip`/`mie` bits 16..16+NLINT-1 and cause codes 16..16+NLINT-1.
- `CNT_W`, default 64: implemented counter width, range 33..64. Bits at or above CNT_W read 0.

Ports:
- `clk` in 1: clock.
- `cpurst` in 1: reset, asynchronous, active-high.
- `csr_wr_en` in 1: CSR write strobe from writeback.
- `csr_wr_idx` in 12: write address.
- `csr_wr_data` in 32: final write value (read-modify-write already resolved upstream).
- `csr_rd_idx` in 12: read address.
- `csr_rd_data` out 32: combinational read data.
- `csr_rd_ill` out 1: read index not implemented.
- `exp_valid` in 1: exception retiring in writeback.
- `exp_cause` in 5: exception code.
- `exp_pc` in 32: pc of the faulting instruction.
- `exp_tval` in 32: trap value.
- `mret` in 1: mret retiring.
- `instr_ret` in 1: one instruction retired this cycle.
- `irq_ms`, `irq_mt`, `irq_me` in 1 each: level interrupt sources.
- `irq_local` in NLINT: level local interrupt sources.
- `int_req` out 1: interrupt pending, enabled, and globally enabled.
- `int_ack` in 1: fetch accepts the interrupt this cycle.
- `int_pc` in 32: resume pc, saved to mepc on ack.
- `trap_vec` out 32: trap target pc.
- `mepc_o` out 32: current mepc, used for the mret target.
- `mstatus_mie` out 1: global interrupt enable.

## Operation
- Implemented CSRs: `mstatus` 0x300 (MIE bit 3, MPIE bit 7, MPP reads 2'b11), `misa` 0x301 (reads 0), `mie` 0x304, `mtvec` 0x305, `mcountinhibit` 0x320 (CY bit 0, IR bit 2), `mscratch` 0x340, `mepc` 0x341 (bit 0 reads 0), `mcause` 0x342, `mtval` 0x343, `mip` 0x344, `mcycle`/`mcycleh` 0xB00/0xB80, `minstret`/`minstreth` 0xB02/0xB82, and 0xF11..0xF14 (read 0).
- Any other read index: `csr_rd_data`=0 and `csr_rd_ill`=1.
- Writes to `mip`, `misa`, and 0xF1x are ignored.
- `mie` bit layout: MSIE bit 3, MTIE bit 7, MEIE bit 11, local enables at bits 16+.
- `mip` is read-only and reflects the live irq inputs, using the same bit layout as `mie`.
- `mtvec`: bits [31:2] are the base; bit 0 is the mode (0 direct, 1 vectored); bit 1 reads 0.
- `int_req` = (mip & mie) != 0 and `mstatus.MIE`.
- Interrupt priority: MEI(11) > MSI(3) > MTI(7) > local, highest index first.
- `trap_vec`:
  - Direct mode: base.
  - Vectored mode with an interrupt pending: base + 4·cause.
  - Exception: always base.
- Per-cycle update priority is: interrupt ack > exception > mret > CSR write.
  - Interrupt ack (int_ack and int_req): MPIE←MIE, MIE←0, mepc←int_pc, mcause←{1, cause}, mtval←0.
  - Exception (exp_valid): MPIE←MIE, MIE←0, mepc←exp_pc, mcause←{0, exp_cause}, mtval←exp_tval.
  - mret: MIE←MPIE, MPIE←1.
- A CSR write in the same cycle as a trap or mret is dropped.
- `int_ack` without `int_req` is ignored.
- Counters:
  - `mcycle` increments every cycle unless CY=1.
  - `minstret` increments on instr_ret unless IR=1.
  - Both wrap from 2^CNT_W−1 to 0.
  - A write to the low or high half replaces only that half and suppresses that counter's increment for the cycle.

## Timing
- Reset values: all registers are 0; `mtvec` is 0 (direct mode); `int_req`=0; `trap_vec`=0; `mepc_o`=0; `mstatus_mie`=0.
- Reset is asynchronous and aborts any update in flight.
- `csr_rd_data`, `int_req`, and `trap_vec` are combinational, with zero latency.
- Writes and trap state updates are visible on the read port the cycle after the clock edge. This block provides no read-after-write bypass; upstream forwarding covers it.
- `int_req` drops the cycle after ack, because MIE is then 0.
- irq inputs are sampled live; a source that deasserts before ack withdraws `int_req`.

## Configuration
- `MCSR_COUNTERS_EN` defined: `mcycle`, `minstret`, and `mcountinhibit` are implemented as above.
- `MCSR_COUNTERS_EN` undefined:
  - No counter flops.
  - Indices 0xB00, 0xB80, 0xB02, 0xB82, and 0x320 read 0 with `csr_rd_ill`=0.
  - Writes to those indices are ignored.

## Test plan
- Reset with cpurst asserted mid-cycle → all outputs 0 immediately; read 0x300 returns 0x00001800.
- Write `mtvec`=0x00001001 and `mie`=0x880, set MIE, assert irq_me and irq_mt → int_req=1, trap_vec=0x0000102C. Ack with int_pc=0x200 → mepc=0x200, mcause=0x8000000B, MIE=0, MPIE=1.
- exp_valid with cause 2, pc 0x40, tval 0xDEAD together with csr_wr_en to 0x340 → mcause=2, mtval=0xDEAD, mscratch unchanged. A following mret → MIE=1 (prior MIE value restored).
- NLINT=4: enable only mie bit 19 and assert irq_local[3] and irq_local[0] → cause 19 selected. In vectored mode with base 0x1000, trap_vec=0x104C.
- Write `mcycle`=0xFFFFFFFF and `mcycleh`=0xFFFFFFFF with CNT_W=64 → the next cycle reads 0. Set CY=1 → value frozen. instr_ret pulsed 3 times with IR=0 → `minstret` reads 3.
- Read 0x7C0 → csr_rd_ill=1, data 0. With `MCSR_COUNTERS_EN` undefined, read 0xB00 → 0 with ill=0.
